// File: rtl/transform_sched.sv
// Butterfly issue scheduler for radix-2 DIT/DIF transforms; stage_done pulses only when TRANSFORM_SCHED_STAGE_PULSE_EN is defined.
// Latency: first issue one cycle after start; PIPE_LAT bubble before short-gap stages and PIPE_LAT drain before done.
// Backpressure: issue fields hold while ready is low; bubble/drain timers run regardless of ready.
module transform_sched #(
    parameter int N                = 8192,
    parameter int LANES            = 2,
    parameter int PIPE_LAT         = 12,
    parameter int STALL_GAP_THRESH = 2,
    localparam int LOGN            = $clog2(N),
    localparam int SW              = $clog2(LOGN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            is_dif,
    input  logic            ready,
    output logic            issue_valid,
    output logic [LOGN-1:0] base_addr,
    output logic [LOGN-1:0] gap,
    output logic [LANES-1:0] lane_mask,
    output logic [LOGN-1:0] tw_idx,
    output logic [SW-1:0]   stage,
    output logic            busy,
    output logic            done,
    output logic            stage_done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_BUBBLE, S_DRAIN} state_t;

    localparam logic [5:0] LAT_LAST = 6'(PIPE_LAT - 1);
    localparam logic [5:0] LAT_PRE  = 6'((PIPE_LAT >= 2) ? PIPE_LAT - 2 : 0);

    state_t          state;
    logic [LOGN-1:0] m_q, gap_q, i_q, j_q;
    logic [SW-1:0]   stage_q;
    logic            dif_q;
    logic [5:0]      cnt_q;

    logic            fire, last_j, last_i, last_stage, stage_end, need_bubble;
    logic [LOGN:0]   j_sum;
    logic [LOGN-1:0] m_nxt, gap_nxt;
    logic [31:0]     gap_nxt_ext;

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
        logic [LOGN-1:0] r;
        for (int b = 0; b < LOGN; b++) r[b] = v[LOGN-1-b];
        return r;
    endfunction

    assign fire        = issue_valid & ready;
    assign j_sum       = {1'b0, j_q} + (LOGN+1)'(LANES);
    assign last_j      = j_sum >= {1'b0, gap_q};
    assign last_i      = i_q == m_q - 1'b1;
    assign last_stage  = stage_q == SW'(LOGN - 1);
    assign stage_end   = last_j & last_i;
    // DIT walks m upward and gap downward; DIF the reverse.
    assign m_nxt       = dif_q ? (m_q >> 1) : (m_q << 1);
    assign gap_nxt     = dif_q ? (gap_q << 1) : (gap_q >> 1);
    assign gap_nxt_ext = 32'(gap_nxt);
    assign need_bubble = gap_nxt_ext < 32'(STALL_GAP_THRESH);

    assign base_addr = issue_valid ? bitrev(i_q) + j_q : '0;
    assign gap       = issue_valid ? gap_q : '0;
    assign tw_idx    = issue_valid ? m_q + i_q : '0;
    assign stage     = stage_q;

    always_comb begin
        lane_mask = '0;
        for (int k = 0; k < LANES; k++) begin
            if (issue_valid && (({1'b0, j_q} + (LOGN+1)'(k)) < {1'b0, gap_q}))
                lane_mask[k] = 1'b1;
        end
    end

`ifdef TRANSFORM_SCHED_STAGE_PULSE_EN
    assign stage_done = fire & stage_end;
`else
    assign stage_done = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            issue_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            dif_q       <= 1'b0;
            m_q         <= '0;
            gap_q       <= '0;
            i_q         <= '0;
            j_q         <= '0;
            stage_q     <= '0;
            cnt_q       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state       <= S_RUN;
                        issue_valid <= 1'b1;
                        busy        <= 1'b1;
                        dif_q       <= is_dif;
                        stage_q     <= '0;
                        i_q         <= '0;
                        j_q         <= '0;
                        m_q         <= is_dif ? LOGN'(N / 2) : LOGN'(1);
                        gap_q       <= is_dif ? LOGN'(1) : LOGN'(N / 2);
                    end
                end
                S_RUN: begin
                    if (fire) begin
                        if (!last_j) begin
                            j_q <= j_sum[LOGN-1:0];
                        end else begin
                            j_q <= '0;
                            if (!last_i) begin
                                i_q <= i_q + 1'b1;
                            end else begin
                                i_q <= '0;
                                if (last_stage) begin
                                    state       <= S_DRAIN;
                                    issue_valid <= 1'b0;
                                    cnt_q       <= '0;
                                    if (PIPE_LAT == 1) begin
                                        done <= 1'b1;
                                        busy <= 1'b0;
                                    end
                                end else begin
                                    stage_q <= stage_q + 1'b1;
                                    m_q     <= m_nxt;
                                    gap_q   <= gap_nxt;
                                    if (need_bubble) begin
                                        state       <= S_BUBBLE;
                                        issue_valid <= 1'b0;
                                        cnt_q       <= '0;
                                    end
                                end
                            end
                        end
                    end
                end
                S_BUBBLE: begin
                    if (cnt_q == LAT_LAST) begin
                        state       <= S_RUN;
                        issue_valid <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                S_DRAIN: begin
                    // done/busy are registered so they land in the final drain cycle.
                    if (cnt_q == LAT_LAST) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == LAT_PRE) begin
                            done <= 1'b1;
                            busy <= 1'b0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_transform_sched.sv
// Randomized bench for transform_sched: two instances (LANES=1, LANES=4) at N=16 against a loop-nest reference model.
module tb_transform_sched;
    localparam int N    = 16;
    localparam int LOGN = 4;
    localparam int PL   = 4;
    localparam int TH   = 2;
`ifdef TRANSFORM_SCHED_STAGE_PULSE_EN
    localparam bit SP_EN = 1'b1;
`else
    localparam bit SP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start0 = 1'b0, dif0 = 1'b0, rdy0 = 1'b0;
    logic start1 = 1'b0, dif1 = 1'b0, rdy1 = 1'b0;
    logic vld0, busy0, done0, sdone0, vld1, busy1, done1, sdone1;
    logic [3:0] base0, gap0, tw0, base1, gap1, tw1;
    logic [0:0] mask0;
    logic [3:0] mask1;
    logic [1:0] stage0, stage1;

    always #5 clk = ~clk;

    transform_sched #(.N(N), .LANES(1), .PIPE_LAT(PL), .STALL_GAP_THRESH(TH)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .is_dif(dif0), .ready(rdy0),
        .issue_valid(vld0), .base_addr(base0), .gap(gap0), .lane_mask(mask0),
        .tw_idx(tw0), .stage(stage0), .busy(busy0), .done(done0), .stage_done(sdone0));

    transform_sched #(.N(N), .LANES(4), .PIPE_LAT(PL), .STALL_GAP_THRESH(TH)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .is_dif(dif1), .ready(rdy1),
        .issue_valid(vld1), .base_addr(base1), .gap(gap1), .lane_mask(mask1),
        .tw_idx(tw1), .stage(stage1), .busy(busy1), .done(done1), .stage_done(sdone1));

    typedef struct {
        int base, gap, mask, tw, stage;
        bit first, last, bubble;
    } item_t;

    typedef struct {
        int vld, busy, done, sdone, base, gap, mask, tw, stage;
    } obs_t;

    item_t exp_q[$];
    int    exp_cnt[LOGN];
    int    n_chk = 0;
    int    n_pass = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    function automatic int rev_bits(input int v);
        int r = 0;
        for (int b = 0; b < LOGN; b++) r = r * 2 + ((v >> b) & 1);
        return r;
    endfunction

    // Expected issue stream straight from the loop nest m / i / j.
    function void build_model(input int lanes, input bit dif);
        exp_q.delete();
        for (int s = 0; s < LOGN; s++) begin
            int m, g;
            m = dif ? (N / 2) >> s : 1 << s;
            g = N / (2 * m);
            exp_cnt[s] = m * ((g + lanes - 1) / lanes);
            for (int i = 0; i < m; i++) begin
                for (int j = 0; j < g; j += lanes) begin
                    item_t it;
                    it.base = (rev_bits(i) + j) % N;
                    it.gap = g;
                    it.tw = m + i;
                    it.stage = s;
                    it.mask = 0;
                    for (int k = 0; k < lanes; k++) if (j + k < g) it.mask += (1 << k);
                    it.first = (i == 0) && (j == 0);
                    it.last = (i == m - 1) && (j + lanes >= g);
                    it.bubble = (s > 0) && (g < TH);
                    exp_q.push_back(it);
                end
            end
        end
    endfunction

    task automatic get_obs(input int u, output obs_t o);
        if (u == 0) begin
            o.vld = int'(vld0); o.busy = int'(busy0); o.done = int'(done0); o.sdone = int'(sdone0);
            o.base = int'(base0); o.gap = int'(gap0); o.mask = int'(mask0); o.tw = int'(tw0);
            o.stage = int'(stage0);
        end else begin
            o.vld = int'(vld1); o.busy = int'(busy1); o.done = int'(done1); o.sdone = int'(sdone1);
            o.base = int'(base1); o.gap = int'(gap1); o.mask = int'(mask1); o.tw = int'(tw1);
            o.stage = int'(stage1);
        end
    endtask

    task automatic drive(input int u, input bit st, input bit dif, input bit rdy);
        if (u == 0) begin start0 = st; dif0 = dif; rdy0 = rdy; end
        else begin start1 = st; dif1 = dif; rdy1 = rdy; end
    endtask

    task automatic check_zero(input string tag, input int u);
        obs_t o;
        get_obs(u, o);
        check({tag, "_vld"}, o.vld, 0);
        check({tag, "_busy"}, o.busy, 0);
        check({tag, "_done"}, o.done, 0);
        check({tag, "_sdone"}, o.sdone, 0);
        check({tag, "_base"}, o.base, 0);
        check({tag, "_gap"}, o.gap, 0);
        check({tag, "_mask"}, o.mask, 0);
        check({tag, "_tw"}, o.tw, 0);
        check({tag, "_stage"}, o.stage, 0);
    endtask

    // mode 0: ready=1; mode 1: random ready; mode 2: ready 1,0,0,1 then 1.
    task automatic run_one(input int u, input bit dif, input int mode, input bit hold_start);
        obs_t o;
        int t = 0, fires = 0, last_fire_t = 0, idle_run = 0, first_vld_t = -1, total;
        int seen_cnt[LOGN];
        bit got_done = 1'b0, rdy, exp_sd;
        for (int s = 0; s < LOGN; s++) seen_cnt[s] = 0;
        build_model((u == 0) ? 1 : 4, dif);
        total = exp_q.size();
        @(posedge clk); #1;
        drive(u, 1'b1, dif, 1'b1);
        while (!got_done && t < 400) begin
            @(posedge clk); #1;
            t++;
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
            else rdy = !(t == 2 || t == 3);
            drive(u, hold_start, dif, rdy);
            @(negedge clk);
            get_obs(u, o);
            exp_sd = 1'b0;
            if (o.vld != 0) begin
                if (first_vld_t < 0) first_vld_t = t;
                if (exp_q.size() == 0) begin
                    check("extra_issue", 1, 0);
                end else begin
                    check("base_addr", o.base, exp_q[0].base);
                    check("gap", o.gap, exp_q[0].gap);
                    check("lane_mask", o.mask, exp_q[0].mask);
                    check("tw_idx", o.tw, exp_q[0].tw);
                    check("stage", o.stage, exp_q[0].stage);
                    if (rdy) begin
                        fires++;
                        seen_cnt[o.stage]++;
                        if (exp_q[0].first) check("bubble_len", idle_run, exp_q[0].bubble ? PL : 0);
                        idle_run = 0;
                        exp_sd = SP_EN && exp_q[0].last;
                        last_fire_t = t;
                        void'(exp_q.pop_front());
                    end
                end
            end else if (o.busy != 0) begin
                idle_run++;
            end
            check("stage_done", o.sdone, int'(exp_sd));
            if (o.done != 0) begin
                got_done = 1'b1;
                check("done_latency", t - last_fire_t, PL);
                check("busy_at_done", o.busy, 0);
                check("issues_left", exp_q.size(), 0);
            end else begin
                check("busy", o.busy, 1);
            end
        end
        if (!got_done) check("done_timeout", 0, 1);
        check("issue_count", fires, total);
        for (int s = 0; s < LOGN; s++) check("stage_issue_count", seen_cnt[s], exp_cnt[s]);
        check("first_issue_cycle", first_vld_t, 1);
        if (u == 0 && !dif && mode == 0) check("done_cycle", t, 40);
        @(posedge clk); #1;
        drive(u, 1'b0, dif, 1'b1);
        repeat (3) begin
            @(negedge clk);
            get_obs(u, o);
            check("post_vld", o.vld, 0);
            check("post_busy", o.busy, 0);
            check("post_done", o.done, 0);
        end
    endtask

    task automatic run_abort(input int u);
        obs_t o;
        int k, dones = 0, busies = 0;
        @(posedge clk); #1;
        drive(u, 1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(u, 1'b0, 1'b0, 1'b1);
        k = int'($urandom_range(3, 15));
        repeat (k) @(posedge clk);
        #2;
        get_obs(u, o);
        check("abort_pre_busy", o.busy, 1);
        rst_n = 1'b0;
        #1;
        check_zero("abort", u);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * PL + 40) begin
            @(negedge clk);
            get_obs(u, o);
            dones += o.done;
            busies += o.busy;
        end
        check("abort_no_done", dones, 0);
        check("abort_no_busy", busies, 0);
        run_one(u, 1'b0, 0, 1'b0);
    endtask

    initial begin
        int ru, rd, rh;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_u0", 0);
        check_zero("reset_u1", 1);
        @(negedge clk);
        rst_n = 1'b1;
        run_one(0, 1'b0, 0, 1'b0);
        run_one(1, 1'b0, 0, 1'b0);
        run_one(0, 1'b1, 0, 1'b0);
        run_one(0, 1'b0, 2, 1'b0);
        run_one(0, 1'b1, 1, 1'b1);
        run_one(1, 1'b1, 1, 1'b0);
        run_one(1, 1'b0, 0, 1'b1);
        run_abort(0);
        repeat (4) begin
            ru = int'($urandom_range(0, 1));
            rd = int'($urandom_range(0, 1));
            rh = int'($urandom_range(0, 1));
            run_one(ru, rd != 0, 1, rh != 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
